// File: rtl/circular_buffer.sv
// circular_buffer: power-of-two FIFO with wrap-bit pointers,
// first-word-fall-through head and registered overflow/underflow pulses.
module circular_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  wready,
    input  logic                  ren,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Status is derived purely from the registered pointers.
    assign empty  = (wptr == rptr);
    assign full   = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0])
                 && (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
    assign usedw  = wptr - rptr;
    assign wready = !full;
    assign rvalid = !empty;

    // A full buffer rejects writes even when a read frees a slot that edge.
    assign wr_acc = wen && !full;
    assign rd_acc = ren && !empty;

    // Head word falls through; nothing stale leaks out while empty.
    assign dout = empty ? '0 : mem[rptr[ADDR_WIDTH-1:0]];

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= din;
        end
    end

    // Pointers wrap naturally; reset drops all buffered words at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_acc) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    // Single-cycle error pulses for requests that hit a full/empty buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wen && full;
            underflow <= ren && empty;
        end
    end

endmodule

// File: tb/tb_circular_buffer.sv
// tb_circular_buffer: queue-based reference model feeding a scoreboard
// that a negedge monitor drains whenever the DUT hands out a word.
module tb_circular_buffer;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset;
    logic          wen;
    logic [DW-1:0] din;
    logic          wready;
    logic          ren;
    logic          rvalid;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic [AW:0]   usedw;
    logic          overflow;
    logic          underflow;

    circular_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .wen       (wen),
        .din       (din),
        .wready    (wready),
        .ren       (ren),
        .rvalid    (rvalid),
        .dout      (dout),
        .full      (full),
        .empty     (empty),
        .usedw     (usedw),
        .overflow  (overflow),
        .underflow (underflow)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model[$];
    logic [DW-1:0] exp_q[$];
    int            m_cnt = 0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    logic          mon_en = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from its own
    // occupancy, queues expected read data, then commits after the edge.
    task automatic cycle(input logic w, input logic [DW-1:0] d,
                         input logic r);
        int   cnt;
        logic nx_ovf;
        logic nx_udf;
        cnt = model.size();
        wen = w;
        din = d;
        ren = r;
        nx_ovf = w && (cnt == DEPTH);
        nx_udf = r && (cnt == 0);
        if (r && cnt > 0) exp_q.push_back(model.pop_front());
        if (w && cnt < DEPTH) model.push_back(d);
        @(posedge clk);
        #1;
        m_cnt = model.size();
        m_ovf = nx_ovf;
        m_udf = nx_udf;
    endtask

    // Monitor: status against model every cycle, data on each handshake.
    always @(negedge clk) begin
        if (mon_en && reset === 1'b1) begin
            chk("usedw", 32'(usedw), 32'(m_cnt));
            chk("full", 32'(full), 32'(m_cnt == DEPTH));
            chk("empty", 32'(empty), 32'(m_cnt == 0));
            chk("wready", 32'(wready), 32'(m_cnt != DEPTH));
            chk("rvalid", 32'(rvalid), 32'(m_cnt != 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_udf));
            if (m_cnt == 0) chk("dout_empty", 32'(dout), 32'h0);
            if (rvalid && ren) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_read", 32'(dout), 32'hdead);
                end else begin
                    chk("rdata", 32'(dout), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int wr;
        int rd;
        int cnt;
        int guard;
        logic w;
        logic r;

        reset = 1'b1;
        wen   = 1'b0;
        ren   = 1'b0;
        din   = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_usedw", 32'(usedw), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_wready", 32'(wready), 32'h1);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_udf", 32'(underflow), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        mon_en = 1'b1;

        // idle after reset
        cycle(1'b0, '0, 1'b0);

        // fill then overflow with a word that must never appear
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h11 + i), 1'b0);
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_usedw", 32'(usedw), 32'(DEPTH));
        cycle(1'b1, 8'h99, 1'b0);
        chk("ovf_pulse", 32'(overflow), 32'h1);
        chk("ovf_usedw", 32'(usedw), 32'(DEPTH));
        cycle(1'b0, '0, 1'b0);
        chk("ovf_clear", 32'(overflow), 32'h0);

        // drain in order, then underflow
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
        chk("drain_empty", 32'(empty), 32'h1);
        cycle(1'b0, '0, 1'b1);
        chk("udf_pulse", 32'(underflow), 32'h1);
        chk("udf_usedw", 32'(usedw), 32'h0);
        cycle(1'b0, '0, 1'b0);

        // wrap-around with occupancy held in 1..5
        wr = 0;
        rd = 0;
        guard = 0;
        while ((wr < 20 || rd < 20) && guard < 1000) begin
            guard++;
            cnt = model.size();
            w = (wr < 20) && (cnt < 5) && (cnt == 0 || $urandom_range(0, 1) == 1);
            r = (rd < 20) && (cnt > 1 || (cnt == 1 && (w || wr == 20)))
                && $urandom_range(0, 1) == 1;
            if (w) wr++;
            if (r) rd++;
            cycle(w, 8'($urandom), r);
        end
        chk("wrap_done", 32'(wr + rd), 32'd40);

        // simultaneous while full
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0);
        cycle(1'b1, 8'h77, 1'b1);
        chk("sim_full_usedw", 32'(usedw), 32'(DEPTH - 1));
        chk("sim_full_ovf", 32'(overflow), 32'h1);
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b1);

        // simultaneous while empty
        cycle(1'b1, 8'h55, 1'b1);
        chk("sim_empty_usedw", 32'(usedw), 32'h1);
        chk("sim_empty_udf", 32'(underflow), 32'h1);
        cycle(1'b0, '0, 1'b1);

        // simultaneous mid-level keeps occupancy
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom), 1'b1);
        chk("sim_mid_usedw", 32'(usedw), 32'h3);

        // random traffic
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 1) == 1, 8'($urandom),
                  $urandom_range(0, 2) != 0);
        while (model.size() > 0) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // asynchronous reset with words buffered
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
        chk("pre_rst_usedw", 32'(usedw), 32'h5);
        wen = 1'b0;
        ren = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("arst_empty", 32'(empty), 32'h1);
        chk("arst_dout", 32'(dout), 32'h0);
        chk("arst_usedw", 32'(usedw), 32'h0);
        chk("arst_rvalid", 32'(rvalid), 32'h0);
        model.delete();
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        cycle(1'b1, 8'hA5, 1'b0);
        chk("post_rst_dout", 32'(dout), 32'hA5);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
